resp_arbiter: RTL and testbench
===============================

# resp_arbiter

Reference-clock-domain arbiter that shares the single TX async-FIFO write port between two response sources: register-file read data (one frame) and ALU results (two frames). Each source has a one-entry holding slot. A small FSM grants one source at a time and pushes its frames into the FIFO, stalling on FIFO full. ALU results are serialized LSB frame first. It sits between Reg_file/ALU outputs and the ASYNC_FIFO write side, and takes over the response path from the system controller.

## Interface
Parameters:
- FRAME_WIDTH, 8, width of one FIFO/UART frame
- ALU_DATA_WIDTH, 16, ALU result width; must equal 2*FRAME_WIDTH

Ports:
- CLK  in  1  reference clock; one clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- rf_data  in  FRAME_WIDTH  register-file read data
- rf_vld  in  1  single-cycle pulse, rf_data valid
- alu_data  in  ALU_DATA_WIDTH  ALU result
- alu_vld  in  1  single-cycle pulse, alu_data valid
- fifo_full  in  1  FIFO write-side full flag
- fifo_wdata  out  FRAME_WIDTH  frame presented to FIFO
- fifo_winc  out  1  FIFO write strobe, one frame per high cycle
- busy  out  1  any slot pending or FSM not IDLE
- ovr_err  out  1  single-cycle pulse, an incoming result was dropped

## Operation
- Slots: rf_slot {pend, data[FRAME_WIDTH]}, alu_slot {pend, data[ALU_DATA_WIDTH]}. A vld pulse loads the slot and sets pend at the clock edge.
- Overrun: vld while that slot's pend=1 and the slot is not being freed that cycle -> new data dropped, old data kept, ovr_err=1 for that cycle. vld in the same cycle the slot's final frame is written -> free-and-load (new data accepted, pend stays 1, no ovr_err).
- FSM states: IDLE, SEND_RF, SEND_ALU_LO, SEND_ALU_HI.
  - IDLE: no pend -> IDLE; only rf pend -> SEND_RF; only alu pend -> SEND_ALU_LO; both pend -> arbitration (see Configuration).
  - SEND_RF: fifo_wdata=rf_slot.data; write when !fifo_full -> clear rf pend, go to IDLE.
  - SEND_ALU_LO: fifo_wdata=alu_slot.data[FRAME_WIDTH-1:0]; write -> SEND_ALU_HI.
  - SEND_ALU_HI: fifo_wdata=alu_slot.data[ALU_DATA_WIDTH-1:FRAME_WIDTH]; write -> clear alu pend, IDLE.
- fifo_winc = (state != IDLE) && !fifo_full, decoded combinationally from the registered state. fifo_full high holds the state, with fifo_wdata stable and no write. No frame is ever written while fifo_full=1.
- An ALU frame pair is never interleaved with an RF frame.
- Reset: state=IDLE, both pend=0, slot data=0, last_grant=RF, fifo_winc=0, fifo_wdata=0, busy=0, ovr_err=0. Reset mid-operation discards any partial ALU pair; no frame is written afterwards for it.

## Timing
- vld pulse in cycle N -> slot loaded at end of N -> IDLE grants in N+1 -> SEND state in N+2 -> first fifo_winc in N+2 if not full.
- Minimum latency RF: 2 cycles vld-to-winc. ALU: frames in N+2 and N+3.
- Throughput: IDLE cycle between grants. RF response every 2 cycles; ALU every 3 cycles.
- Each fifo_full cycle adds exactly one cycle of delay.
- busy is registered-state-derived: high from cycle N+1 until the cycle after the last write.

## Configuration
- RESP_ARB_ROUND_ROBIN_EN defined: when both slots are pending in IDLE, grant the source not in last_grant. last_grant updates on every grant.
- Not defined: fixed priority, ALU always wins over RF. The last_grant register is not built. RF can starve only while ALU results keep arriving.

## Structure
- Package resp_arb_pkg: state enum (IDLE, SEND_RF, SEND_ALU_LO, SEND_ALU_HI), source id constants SRC_RF/SRC_ALU.
- Sub-module resp_hold_slot (parameter WIDTH): holding register with pend flag, load/free-and-load/overrun logic. Instantiated twice.
- Top: FSM, arbitration, output mux.

## Test plan
- rf_vld with rf_data=0xA5, fifo_full=0 -> fifo_winc one cycle 2 cycles later, wdata=0xA5. busy then drops.
- alu_vld with alu_data=0x1234 -> winc in consecutive cycles with wdata 0x34 then 0x12.
- rf_vld and alu_vld in the same cycle (0x11, 0xBEEF), round-robin build after reset -> ALU is granted first (last_grant=RF), giving 0xEF, 0xBE, 0x11. Without the macro, ALU is also first. Repeat with both pending again: round-robin gives RF first, fixed priority gives ALU first.
- fifo_full held high 5 cycles across SEND_ALU_HI -> no winc while full, wdata holds 0x12. Write occurs on the first !full cycle.
- Second rf_vld (0x22) while 0x11 is pending and full is held -> ovr_err pulse, only 0x11 written. A second rf_vld in the exact write cycle of 0x11 -> no ovr_err, 0x22 is written next.
- RST asserted between ALU LO and HI frames -> all outputs 0 immediately. After release, no HI frame is written and busy=0.

Source files
------------

// File: rtl/resp_arb_pkg.sv
// Shared types for the response arbiter: FSM state encoding and source ids.
// The optional RESP_ARB_ROUND_ROBIN_EN build uses SRC_RF/SRC_ALU for last_grant.
package resp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_RF     = 2'd1,
    SEND_ALU_LO = 2'd2,
    SEND_ALU_HI = 2'd3
  } arb_state_t;

  localparam logic SRC_RF  = 1'b0;
  localparam logic SRC_ALU = 1'b1;

endpackage

// File: rtl/resp_hold_slot.sv
// One-entry holding slot with pend flag. A load in the same cycle the slot is
// freed is accepted; a load while pending and not freed is dropped (o_ovr).
module resp_hold_slot #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_free,
  output logic             o_pend,
  output logic [WIDTH-1:0] o_data,
  output logic             o_ovr
);

  logic             r_pend;
  logic [WIDTH-1:0] r_data;
  logic             w_load;

  assign w_load = i_vld && (!r_pend || i_free);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend <= 1'b0;
      r_data <= '0;
    end else if (w_load) begin
      r_pend <= 1'b1;
      r_data <= i_data;
    end else if (i_free) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_data = r_data;
  assign o_ovr  = i_vld && r_pend && !i_free;

endmodule

// File: rtl/resp_arbiter.sv
// Shares the TX FIFO write port between RF read data (1 frame) and ALU results
// (2 frames, LSB first). Define RESP_ARB_ROUND_ROBIN_EN for round-robin grant.
// FIFO handshake: a frame is written in every cycle where fifo_winc is high,
// which only happens in a SEND state with fifo_full low; full holds the state.
module resp_arbiter
  import resp_arb_pkg::*;
#(
  parameter int FRAME_WIDTH    = 8,
  parameter int ALU_DATA_WIDTH = 16  // must be 2*FRAME_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [FRAME_WIDTH-1:0]    rf_data,
  input  logic                      rf_vld,
  input  logic [ALU_DATA_WIDTH-1:0] alu_data,
  input  logic                      alu_vld,
  input  logic                      fifo_full,
  output logic [FRAME_WIDTH-1:0]    fifo_wdata,
  output logic                      fifo_winc,
  output logic                      busy,
  output logic                      ovr_err,
  output logic [1:0]                dbg_state
);

  arb_state_t                r_state;
  arb_state_t                w_next;
  logic                      w_rf_pend;
  logic                      w_alu_pend;
  logic [FRAME_WIDTH-1:0]    w_rf_data;
  logic [ALU_DATA_WIDTH-1:0] w_alu_data;
  logic                      w_rf_ovr;
  logic                      w_alu_ovr;
  logic                      w_write;
  logic                      w_rf_free;
  logic                      w_alu_free;
  logic                      w_grant_alu;

  assign w_write    = (r_state != IDLE) && !fifo_full;
  assign w_rf_free  = w_write && (r_state == SEND_RF);
  assign w_alu_free = w_write && (r_state == SEND_ALU_HI);

  resp_hold_slot #(.WIDTH(FRAME_WIDTH)) u_rf_slot (
    .CLK    (CLK),
    .RST    (RST),
    .i_vld  (rf_vld),
    .i_data (rf_data),
    .i_free (w_rf_free),
    .o_pend (w_rf_pend),
    .o_data (w_rf_data),
    .o_ovr  (w_rf_ovr)
  );

  resp_hold_slot #(.WIDTH(ALU_DATA_WIDTH)) u_alu_slot (
    .CLK    (CLK),
    .RST    (RST),
    .i_vld  (alu_vld),
    .i_data (alu_data),
    .i_free (w_alu_free),
    .o_pend (w_alu_pend),
    .o_data (w_alu_data),
    .o_ovr  (w_alu_ovr)
  );

`ifdef RESP_ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On contention, favour whichever source was not granted last.
  assign w_grant_alu = w_alu_pend && (!w_rf_pend || (r_last_grant == SRC_RF));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last_grant <= SRC_RF;
    end else if ((r_state == IDLE) && (w_rf_pend || w_alu_pend)) begin
      r_last_grant <= w_grant_alu ? SRC_ALU : SRC_RF;
    end
  end
`else
  assign w_grant_alu = w_alu_pend;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    fifo_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_grant_alu) begin
          w_next = SEND_ALU_LO;
        end else if (w_rf_pend) begin
          w_next = SEND_RF;
        end
      end
      SEND_RF: begin
        fifo_wdata = w_rf_data;
        if (!fifo_full) w_next = IDLE;
      end
      SEND_ALU_LO: begin
        fifo_wdata = w_alu_data[FRAME_WIDTH-1:0];
        if (!fifo_full) w_next = SEND_ALU_HI;
      end
      SEND_ALU_HI: begin
        fifo_wdata = w_alu_data[ALU_DATA_WIDTH-1:FRAME_WIDTH];
        if (!fifo_full) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign fifo_winc = w_write;
  assign busy      = w_rf_pend || w_alu_pend || (r_state != IDLE);
  assign ovr_err   = w_rf_ovr || w_alu_ovr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_resp_arbiter.sv
// Bench for resp_arbiter: directed scenarios then random traffic, checked per
// cycle against a job-queue model of the arbiter and a frame-order scoreboard.
module tb_resp_arbiter;

  localparam int FW = 8;
  localparam int AW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [FW-1:0] rf_data;
  logic          rf_vld;
  logic [AW-1:0] alu_data;
  logic          alu_vld;
  logic          fifo_full;
  logic [FW-1:0] fifo_wdata;
  logic          fifo_winc;
  logic          busy;
  logic          ovr_err;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] got_q[$];

  bit            m_rf_pend;
  bit            m_alu_pend;
  logic [FW-1:0] m_rf_data;
  logic [AW-1:0] m_alu_data;
  logic [FW-1:0] m_job_q[$];
  bit            m_job_alu;
  bit            m_last_alu;

  logic          obs_winc;
  logic [FW-1:0] obs_wdata;
  logic          obs_busy;
  logic          obs_ovr;

  resp_arbiter #(.FRAME_WIDTH(FW), .ALU_DATA_WIDTH(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rf_data    (rf_data),
    .rf_vld     (rf_vld),
    .alu_data   (alu_data),
    .alu_vld    (alu_vld),
    .fifo_full  (fifo_full),
    .fifo_wdata (fifo_wdata),
    .fifo_winc  (fifo_winc),
    .busy       (busy),
    .ovr_err    (ovr_err),
    .dbg_state  (dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rf_pend  = 0;
    m_alu_pend = 0;
    m_rf_data  = '0;
    m_alu_data = '0;
    m_job_q.delete();
    m_job_alu  = 0;
    m_last_alu = 0;
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_winc"}, fifo_winc, 0);
    chk({tag, "_wdata"}, fifo_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, ovr_err, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // One clock: drive inputs, check at negedge against the model, advance model.
  task automatic cycle(input bit rv, input logic [FW-1:0] rd, input bit av,
                       input logic [AW-1:0] ad, input bit full);
    bit            idle, e_winc, e_busy, e_ovr, fin_rf, fin_alu, g_alu;
    logic [FW-1:0] e_wdata;
    rf_vld    = rv;
    rf_data   = rd;
    alu_vld   = av;
    alu_data  = ad;
    fifo_full = full;
    @(negedge CLK);
    idle    = (m_job_q.size() == 0);
    e_winc  = !idle && !full;
    e_wdata = idle ? '0 : m_job_q[0];
    fin_rf  = e_winc && !m_job_alu && (m_job_q.size() == 1);
    fin_alu = e_winc && m_job_alu && (m_job_q.size() == 1);
    e_busy  = m_rf_pend || m_alu_pend || !idle;
    e_ovr   = (rv && m_rf_pend && !fin_rf) || (av && m_alu_pend && !fin_alu);
    obs_winc  = fifo_winc;
    obs_wdata = fifo_wdata;
    obs_busy  = busy;
    obs_ovr   = ovr_err;
    chk("winc", fifo_winc, e_winc);
    if (!idle) chk("wdata", fifo_wdata, e_wdata);
    chk("busy", busy, e_busy);
    chk("ovr_err", ovr_err, e_ovr);
    if (fifo_winc === 1'b1) begin
      got_q.push_back(fifo_wdata);
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("sb_order", fifo_wdata, exp_q.pop_front());
    end
    if (idle) begin
`ifdef RESP_ARB_ROUND_ROBIN_EN
      g_alu = m_alu_pend && (!m_rf_pend || !m_last_alu);
`else
      g_alu = m_alu_pend;
`endif
      if (m_rf_pend || m_alu_pend) begin
        m_last_alu = g_alu;
        m_job_alu  = g_alu;
        if (g_alu) begin
          m_job_q.push_back(m_alu_data[7:0]);
          m_job_q.push_back(m_alu_data[15:8]);
          exp_q.push_back(m_alu_data[7:0]);
          exp_q.push_back(m_alu_data[15:8]);
        end else begin
          m_job_q.push_back(m_rf_data);
          exp_q.push_back(m_rf_data);
        end
      end
    end else if (e_winc) begin
      void'(m_job_q.pop_front());
    end
    if (fin_rf) m_rf_pend = 0;
    if (fin_alu) m_alu_pend = 0;
    if (rv && !m_rf_pend) begin
      m_rf_pend = 1;
      m_rf_data = rd;
    end
    if (av && !m_alu_pend) begin
      m_alu_pend = 1;
      m_alu_data = ad;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 0);
  endtask

  // Expected frames packed first-frame-most-significant in the low n bytes.
  task automatic check_seq(input string tag, input logic [23:0] seq, input int n);
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) chk({tag, "_frame"}, got_q[i], seq[8*(n-1-i) +: 8]);
    end
    got_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    chk_outputs_zero("reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    got_q.delete();
  endtask

  initial begin
    rf_vld    = 0;
    rf_data   = '0;
    alu_vld   = 0;
    alu_data  = '0;
    fifo_full = 0;
    RST       = 1'b1;
    #2;
    do_reset();

    // Single RF response: write two cycles after vld, then busy drops.
    cycle(1, 8'hA5, 0, '0, 0);
    cycle(0, '0, 0, '0, 0);
    chk("t1_grant_no_winc", obs_winc, 0);
    chk("t1_busy_early", obs_busy, 1);
    cycle(0, '0, 0, '0, 0);
    chk("t1_winc", obs_winc, 1);
    chk("t1_wdata", obs_wdata, 8'hA5);
    cycle(0, '0, 0, '0, 0);
    chk("t1_busy_drop", obs_busy, 0);
    idle_cycles(2);
    check_seq("t1", 24'h0000A5, 1);

    // ALU result, LSB frame first in consecutive cycles.
    cycle(0, '0, 1, 16'h1234, 0);
    idle_cycles(5);
    check_seq("t2", 24'h003412, 2);

    // Simultaneous requests after reset, then again with last grant = ALU.
    do_reset();
    cycle(1, 8'h11, 1, 16'hBEEF, 0);
    idle_cycles(6);
    check_seq("t3a", 24'hEFBE11, 3);
    cycle(0, '0, 1, 16'h5678, 0);
    idle_cycles(4);
    check_seq("t3b", 24'h007856, 2);
    cycle(1, 8'h33, 1, 16'hCAFE, 0);
    idle_cycles(6);
`ifdef RESP_ARB_ROUND_ROBIN_EN
    check_seq("t3c", 24'h33FECA, 3);
`else
    check_seq("t3c", 24'hFECA33, 3);
`endif

    // FIFO full held five cycles while the HI frame is waiting.
    cycle(0, '0, 1, 16'h1234, 0);
    idle_cycles(2);
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 0, '0, 1);
      chk("t4_full_no_winc", obs_winc, 0);
      chk("t4_full_wdata", obs_wdata, 8'h12);
    end
    cycle(0, '0, 0, '0, 0);
    chk("t4_release_winc", obs_winc, 1);
    chk("t4_release_wdata", obs_wdata, 8'h12);
    idle_cycles(2);
    check_seq("t4", 24'h003412, 2);

    // Overrun while the RF slot is stalled, then free-and-load on the write cycle.
    cycle(1, 8'h11, 0, '0, 1);
    cycle(0, '0, 0, '0, 1);
    cycle(1, 8'h22, 0, '0, 1);
    chk("t5_ovr_pulse", obs_ovr, 1);
    cycle(0, '0, 0, '0, 1);
    chk("t5_ovr_single", obs_ovr, 0);
    idle_cycles(4);
    check_seq("t5a", 24'h000011, 1);
    cycle(1, 8'h11, 0, '0, 0);
    cycle(0, '0, 0, '0, 0);
    cycle(1, 8'h22, 0, '0, 0);
    chk("t5_fl_winc", obs_winc, 1);
    chk("t5_fl_wdata", obs_wdata, 8'h11);
    chk("t5_fl_no_ovr", obs_ovr, 0);
    idle_cycles(4);
    check_seq("t5b", 24'h001122, 2);

    // Reset between the LO and HI frames of an ALU pair.
    cycle(0, '0, 1, 16'hABCD, 0);
    idle_cycles(2);
    RST = 1'b1;
    #1;
    chk_outputs_zero("t6_async");
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle_cycles(4);
    chk("t6_busy", obs_busy, 0);
    check_seq("t6", 24'h0000CD, 1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 4) == 0,
            16'($urandom), $urandom_range(0, 3) == 0);
    end
    idle_cycles(8);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
